// File: rtl/regfile_dump_pkg.sv
// Shared definitions for the register-file dump engine: FSM state encoding
// and the default geometry of the scanned register file.
package regfile_dump_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int NREGS_DEF = 32;
  localparam int DW_DEF    = 32;

endpackage

// File: rtl/regfile_dump.sv
// Walks every register of a regfile through its combinational read port and
// streams each value out as a valid/ready beat, then pulses done.
module regfile_dump
  import regfile_dump_pkg::*;
#(
  parameter int NREGS = NREGS_DEF,
  parameter int DW    = DW_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     abort,
  output logic [$clog2(NREGS)-1:0] ra,
  input  logic [DW-1:0]            rd,
  output logic [DW-1:0]            out_data,
  output logic [$clog2(NREGS)-1:0] out_idx,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     busy,
  output logic                     done
);

  localparam int IW = $clog2(NREGS);
  localparam logic [IW-1:0] LAST = IW'(NREGS - 1);

  state_t        state;
  logic [IW-1:0] idx;

  // idx returns to 0 whenever the FSM goes back to IDLE, so ra reads 0 there.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      out_data  <= '0;
      out_idx   <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= READ;
            idx   <= '0;
          end
        end
        READ: begin
          if (abort) begin
            state <= IDLE;
            idx   <= '0;
          end else begin
            out_data  <= rd;
            out_idx   <= idx;
            out_valid <= 1'b1;
            state     <= SEND;
          end
        end
        SEND: begin
          // abort beats a simultaneous handshake: the beat is dropped, not sent
          if (abort) begin
            state     <= IDLE;
            idx       <= '0;
            out_valid <= 1'b0;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            if (idx == LAST) begin
              state <= DONE;
            end else begin
              idx   <= idx + 1'b1;
              state <= READ;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          idx   <= '0;
        end
        default: begin
          state     <= IDLE;
          idx       <= '0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign ra   = idx;
  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule

// File: doc/regfile_dump.md
REGFILE_DUMP -- requirements
Module: regfile_dump

Interface
REQ-001 Parameter NREGS, default 32, number of registers scanned, index 0..NREGS-1.
REQ-002 Parameter DW, default 32, register data width.
REQ-003 Port clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port rst  input  1  reset, synchronous, active-high.
REQ-005 Port start  input  1  one-cycle request to begin a full dump; sampled only in IDLE.
REQ-006 Port abort  input  1  terminates a dump in progress; ignored in IDLE.
REQ-007 Port ra  output  $clog2(NREGS)  address to regfile combinational read port.
REQ-008 Port rd  input  DW  data from regfile read port for address ra, same cycle.
REQ-009 Port out_data  output  DW  registered register value of current beat.
REQ-010 Port out_idx  output  $clog2(NREGS)  register index of current beat.
REQ-011 Port out_valid  output  1  beat present on out_data/out_idx.
REQ-012 Port out_ready  input  1  consumer accepts beat when high with out_valid.
REQ-013 Port busy  output  1  high in any state other than IDLE.
REQ-014 Port done  output  1  one-cycle pulse after final beat accepted.

Function
REQ-015 FSM states IDLE, READ, SEND, DONE; all outputs registered or decoded from registered state.
REQ-016 IDLE: start=1 at an edge -> READ, idx=0; start=0 -> stay IDLE.
REQ-017 READ: ra=idx; at next edge out_data<=rd, out_idx<=idx, out_valid<=1, -> SEND.
REQ-018 SEND: out_valid=1; out_valid&&out_ready at an edge -> idx==NREGS-1 ? DONE : (idx<=idx+1, -> READ).
REQ-019 SEND without out_ready: out_data, out_idx, out_valid held unchanged indefinitely.
REQ-020 DONE: done=1 for exactly one cycle, busy=1, out_valid=0; next edge -> IDLE.
REQ-021 ra equals idx in all states; ra=0 in IDLE.
REQ-022 Timing: start sampled at edge E, out_ready held high -> beat n valid after edge E+2n+1, done high after edge E+2*NREGS, IDLE after edge E+2*NREGS+1.
REQ-023 start while busy (READ/SEND/DONE) has no effect; no queuing.
REQ-024 abort=1 at an edge in READ/SEND/DONE -> IDLE, out_valid=0, done stays 0; abort wins over simultaneous handshake.
REQ-025 start and abort together in IDLE -> start honoured.
REQ-026 idx never exceeds NREGS-1; no wrap to 0 within a dump.
REQ-027 Register 0 is dumped like any other; its value is whatever rd returns (0 from regfile).

Reset
REQ-028 rst=1 at an edge -> IDLE, idx=0, out_data=0, out_idx=0, out_valid=0, busy=0, done=0, from any state.
REQ-029 rst has priority over start, abort and handshake; reset mid-dump produces no further beats and no done.

Structure
REQ-030 Shared package holds the FSM state enum (IDLE, READ, SEND, DONE) and the default NREGS/DW constants.
REQ-031 Single flat module; no sub-module.

Verification
REQ-032 Regfile x1..x4 written 1..4, start, out_ready=1 -> 32 beats idx 0..31 data 0,1,2,3,4,0...; done pulses after edge E+64.
REQ-033 Backpressure: out_ready low 5 cycles while idx=2 valid -> out_data=2, out_idx=2 stable throughout; no beat lost or duplicated.
REQ-034 start pulsed during beat 10 -> dump continues unchanged, exactly 32 beats, single done.
REQ-035 abort at beat 10 -> out_valid=0 next cycle, busy=0, done never pulses; new start -> beat idx 0 again.
REQ-036 rst during SEND at idx=5 -> all outputs 0 next cycle; no done.
REQ-037 Throughput: out_ready=1 -> out_valid toggles 1/0 every cycle, 32 beats over 64 cycles.
